// File: rtl/stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// stream_rr_arbiter
//
// Shares one downstream valid/ready write port (normally the write side of a
// FIFO) among NUM_REQ upstream streams. One requester holds the grant at a
// time. A grant covers a burst that ends on the requester's last marker or
// after MAX_BURST accepted beats, whichever comes first. The next grant is
// chosen round-robin, starting just after the requester that was last served.
// The granted stream is forwarded unchanged together with its index.
//
// Every grant passes through one IDLE cycle. In IDLE all outputs are zero and
// the next requester is picked. In GRANT the outputs are a combinational mux
// of the granted requester's inputs.
//
// Ports
//   clk      in   1               clock, all state updates on the rising edge
//   rst      in   1               synchronous active-high reset; while high,
//                                 every output is forced to zero
//   a_data   in   NUM_REQ*DATA_W  payloads, requester i at [i*DATA_W +: DATA_W]
//   a_valid  in   NUM_REQ         per-requester valid
//   a_last   in   NUM_REQ         per-requester end-of-burst marker
//   a_ready  out  NUM_REQ         per-requester ready, at most one bit set
//   b_data   out  DATA_W          payload of the granted requester
//   b_id     out  clog2(NUM_REQ)  index of the granted requester
//   b_last   out  1               last marker of the granted requester
//   b_valid  out  1               downstream valid
//   b_ready  in   1               downstream ready (FIFO not full)
// -----------------------------------------------------------------------------
module stream_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ*DATA_W-1:0]   a_data,
    input  logic [NUM_REQ-1:0]          a_valid,
    input  logic [NUM_REQ-1:0]          a_last,
    output logic [NUM_REQ-1:0]          a_ready,
    output logic [DATA_W-1:0]           b_data,
    output logic [$clog2(NUM_REQ)-1:0]  b_id,
    output logic                        b_last,
    output logic                        b_valid,
    input  logic                        b_ready
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]    ID_LAST  = ID_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] REQ_ONE  = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ID_W-1:0]   r_grant;
    logic [ID_W-1:0]   w_grant_nxt;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   w_rr_ptr_nxt;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic [CNT_W-1:0]  w_beat_cnt_nxt;

    logic [ID_W-1:0]   w_pick;
    logic              w_any;
    int                w_idx;

    logic              w_sel_valid;
    logic              w_sel_last;
    logic [DATA_W-1:0] w_sel_data;

    logic              w_beat;
    logic              w_burst_end;

    // ---- round-robin pick: first valid requester at or after rr_ptr --------
    // Walking the offsets from the far end towards zero lets the closest valid
    // requester overwrite any farther one, so no early exit is needed.
    // rr_ptr is always below NUM_REQ, so one conditional subtract wraps the
    // index correctly for any requester count, power of two or not.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_idx  = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if ((a_valid & (REQ_ONE << w_idx)) != '0) begin
                w_any  = 1'b1;
                w_pick = ID_W'(w_idx);
            end
        end
    end

    // ---- granted-requester mux ---------------------------------------------
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant == ID_W'(i)) begin
                w_sel_valid = a_valid[i];
                w_sel_last  = a_last[i];
                w_sel_data  = a_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // ---- output stage ------------------------------------------------------
    // Reset overrides the state so that a beat in flight when rst rises is
    // never handshaken: a_ready and b_valid are both low in that cycle.
    always_comb begin
        a_ready = '0;
        b_valid = 1'b0;
        b_data  = '0;
        b_id    = '0;
        b_last  = 1'b0;
        if (!rst && (r_state == GRANT)) begin
            b_valid = w_sel_valid;
            b_data  = w_sel_data;
            b_last  = w_sel_last;
            b_id    = r_grant;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (r_grant == ID_W'(i)) begin
                    a_ready[i] = b_ready;
                end
            end
        end
    end

    // A beat is a completed handshake on the downstream port; it is the same
    // event as the granted requester's own handshake.
    assign w_beat      = b_valid & b_ready;
    assign w_burst_end = w_beat & (w_sel_last | (r_beat_cnt == CNT_LAST));

    // ---- next-state logic --------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant_nxt    = w_pick;
                    w_state_nxt    = GRANT;
                    w_beat_cnt_nxt = '0;
                end
            end
            GRANT: begin
                // The grant is held while the requester has no valid beat;
                // stalled cycles leave the beat counter untouched.
                if (w_burst_end) begin
                    w_state_nxt    = IDLE;
                    w_beat_cnt_nxt = '0;
                    w_rr_ptr_nxt   = (r_grant == ID_LAST) ? '0 : r_grant + 1'b1;
                end else if (w_beat) begin
                    w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ---- state registers ---------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stream_rr_arbiter
//
// Bench for stream_rr_arbiter. The main instance uses NUM_REQ=4, DATA_W=8 and
// MAX_BURST=4. A second instance with NUM_REQ=3 covers round-robin wrap for a
// requester count that is not a power of two. Each requester is fed from a
// beat queue. The expected downstream beats (id, last, data) are pushed to a
// scoreboard queue when the stimulus is set up, and they are popped as the DUT
// hands them over.
// -----------------------------------------------------------------------------
module tb_stream_rr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;
    localparam int ID_W      = $clog2(NUM_REQ);

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ*DATA_W-1:0] a_data;
    logic [NUM_REQ-1:0]        a_valid;
    logic [NUM_REQ-1:0]        a_last;
    logic [NUM_REQ-1:0]        a_ready;
    logic [DATA_W-1:0]         b_data;
    logic [ID_W-1:0]           b_id;
    logic                      b_last;
    logic                      b_valid;
    logic                      b_ready;

    logic [3*DATA_W-1:0]       a3_data;
    logic [2:0]                a3_valid;
    logic [2:0]                a3_last;
    logic [2:0]                a3_ready;
    logic [DATA_W-1:0]         b3_data;
    logic [1:0]                b3_id;
    logic                      b3_last;
    logic                      b3_valid;
    logic                      b3_ready;

    stream_rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .a_data  (a_data),
        .a_valid (a_valid),
        .a_last  (a_last),
        .a_ready (a_ready),
        .b_data  (b_data),
        .b_id    (b_id),
        .b_last  (b_last),
        .b_valid (b_valid),
        .b_ready (b_ready)
    );

    stream_rr_arbiter #(
        .NUM_REQ   (3),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut3 (
        .clk     (clk),
        .rst     (rst),
        .a_data  (a3_data),
        .a_valid (a3_valid),
        .a_last  (a3_last),
        .a_ready (a3_ready),
        .b_data  (b3_data),
        .b_id    (b3_id),
        .b_last  (b3_last),
        .b_valid (b3_valid),
        .b_ready (b3_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [DATA_W:0]      src_q [NUM_REQ][$];   // {last, data} per requester
    logic [ID_W+DATA_W:0] exp_q [$];            // {id, last, data}
    logic [2+DATA_W:0]    exp3_q [$];
    int                   beat_cyc [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [ID_W+DATA_W:0] mk(input int id, input logic last,
                                                input logic [DATA_W-1:0] data);
        return {ID_W'(id), last, data};
    endfunction

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_q[i].size() > 0) begin
                a_valid[i]                  = 1'b1;
                a_last[i]                   = src_q[i][0][DATA_W];
                a_data[i*DATA_W +: DATA_W]  = src_q[i][0][DATA_W-1:0];
            end else begin
                a_valid[i]                  = 1'b0;
                a_last[i]                   = 1'b0;
                a_data[i*DATA_W +: DATA_W]  = '0;
            end
        end
    endtask

    task automatic push_src(input int i, input logic last, input logic [DATA_W-1:0] data);
        src_q[i].push_back({last, data});
    endtask

    // One clock cycle: observe and check at the falling edge, then retire the
    // accepted source beats and drive new inputs just after the rising edge.
    task automatic step();
        logic [NUM_REQ-1:0] acc;
        @(negedge clk);
        chk("ready_onehot", 32'($countones(a_ready) <= 1), 32'd1);
        if (rst) begin
            chk("rst_a_ready", 32'(a_ready), 32'd0);
            chk("rst_b_valid", 32'(b_valid), 32'd0);
            chk("rst_b_out", 32'({b_id, b_last, b_data}), 32'd0);
        end else if (b_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("beat", 32'({b_id, b_last, b_data}), 32'(exp_q[0]));
                chk("ready_of_grant", 32'(a_ready[b_id]), 32'(b_ready));
                if (b_ready) begin
                    void'(exp_q.pop_front());
                    beat_cyc.push_back(cyc);
                end
            end
        end
        acc = a_ready & a_valid;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i] && src_q[i].size() > 0) begin
                void'(src_q[i].pop_front());
            end
        end
        drive();
    endtask

    task automatic drain(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            step();
            n++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic rdy_pat [7];
        logic [2:0] acc3;

        rst      = 1'b1;
        b_ready  = 1'b1;
        a_valid  = '0;
        a_last   = '0;
        a_data   = '0;
        a3_valid = '0;
        a3_last  = '0;
        a3_data  = '0;
        b3_ready = 1'b1;
        #1;

        // ---- T1: reset with every requester valid ----
        for (int i = 0; i < NUM_REQ; i++) begin
            push_src(i, 1'b1, 8'(8'h50 + i));
            exp_q.push_back(mk(i, 1'b1, 8'(8'h50 + i)));
        end
        drive();
        step();
        step();
        rst = 1'b0;
        c0  = cyc;
        beat_cyc.delete();
        drain("t1_drain", 40);
        chk("t1_first_beat_cycle", 32'(beat_cyc[0]), 32'(c0 + 1));
        chk("t1_grant_spacing", 32'(beat_cyc[1] - beat_cyc[0]), 32'd2);

        // ---- T2: single requester, 3-beat burst then a 1-beat burst ----
        beat_cyc.delete();
        push_src(2, 1'b0, 8'hA1);
        push_src(2, 1'b0, 8'hA2);
        push_src(2, 1'b1, 8'hA3);
        push_src(2, 1'b1, 8'hB1);
        exp_q.push_back(mk(2, 1'b0, 8'hA1));
        exp_q.push_back(mk(2, 1'b0, 8'hA2));
        exp_q.push_back(mk(2, 1'b1, 8'hA3));
        exp_q.push_back(mk(2, 1'b1, 8'hB1));
        drive();
        drain("t2_drain", 40);
        chk("t2_consecutive1", 32'(beat_cyc[1] - beat_cyc[0]), 32'd1);
        chk("t2_consecutive2", 32'(beat_cyc[2] - beat_cyc[0]), 32'd2);
        chk("t2_idle_bubble", 32'(beat_cyc[3] - beat_cyc[2]), 32'd2);

        // ---- T3: fairness, all four always valid with 8-beat streams ----
        rst = 1'b1;
        step();
        rst = 1'b0;
        beat_cyc.delete();
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int k = 0; k < 8; k++) begin
                push_src(i, (k == 7), 8'((i << 4) | k));
            end
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                for (int j = 0; j < MAX_BURST; j++) begin
                    exp_q.push_back(mk(i, (r * 4 + j == 7), 8'((i << 4) | (r * 4 + j))));
                end
            end
        end
        drive();
        drain("t3_drain", 100);
        chk("t3_burst_bubble", 32'(beat_cyc[4] - beat_cyc[3]), 32'd2);
        chk("t3_4_per_5", 32'(beat_cyc[31] - beat_cyc[0]), 32'd38);

        // ---- T5: backpressure during a req1 burst ----
        beat_cyc.delete();
        for (int k = 0; k < 6; k++) begin
            push_src(1, (k == 5), 8'(8'hB0 + k));
            exp_q.push_back(mk(1, (k == 5), 8'(8'hB0 + k)));
        end
        drive();
        rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 7; k++) begin
            b_ready = rdy_pat[k];
            step();
        end
        b_ready = 1'b1;
        drain("t5_drain", 40);
        chk("t5_stall_gap", 32'(beat_cyc[1] - beat_cyc[0]), 32'd3);
        chk("t5_no_early_end", 32'(beat_cyc[3] - beat_cyc[2]), 32'd1);
        chk("t5_end_after_4", 32'(beat_cyc[4] - beat_cyc[3]), 32'd2);

        // ---- T6: reset in the middle of a req3 burst ----
        beat_cyc.delete();
        push_src(3, 1'b0, 8'hD1);
        push_src(3, 1'b0, 8'hD2);
        push_src(3, 1'b0, 8'hD3);
        push_src(3, 1'b1, 8'hD4);
        push_src(1, 1'b1, 8'hE1);
        exp_q.push_back(mk(3, 1'b0, 8'hD1));
        exp_q.push_back(mk(3, 1'b0, 8'hD2));
        exp_q.push_back(mk(1, 1'b1, 8'hE1));
        exp_q.push_back(mk(3, 1'b0, 8'hD3));
        exp_q.push_back(mk(3, 1'b1, 8'hD4));
        drive();
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        c0  = cyc;
        drain("t6_drain", 40);
        chk("t6_regrant_cycle", 32'(beat_cyc[2]), 32'(c0 + 1));

        // ---- T4: NUM_REQ=3, wrap from req2 back to req0 ----
        exp3_q.push_back({2'd1, 1'b1, 8'hC1});
        exp3_q.push_back({2'd2, 1'b1, 8'hC2});
        exp3_q.push_back({2'd0, 1'b1, 8'hC0});
        a3_data  = {8'hC2, 8'hC1, 8'hC0};
        a3_last  = 3'b111;
        a3_valid = 3'b010;
        for (int k = 0; k < 20 && exp3_q.size() > 0; k++) begin
            @(negedge clk);
            acc3 = '0;
            if (b3_valid) begin
                chk("t4_beat", 32'({b3_id, b3_last, b3_data}), 32'(exp3_q[0]));
                acc3 = a3_ready & a3_valid;
                void'(exp3_q.pop_front());
            end
            @(posedge clk);
            #1;
            a3_valid = a3_valid & ~acc3;
            if (k == 0) begin
                a3_valid = a3_valid | 3'b101;
            end
        end
        chk("t4_drain", 32'(exp3_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
